// File: rtl/ram_burst_reader.sv
// ============================================================================
// Module      : ram_burst_reader
// Description : Parametrised synchronous RAM for network weight/activation
//               storage. One write port plus an auto-incrementing burst read
//               engine: the caller hands over a base address and a length
//               once, and the block streams one word per cycle (flagged with
//               o_rd_valid / o_rd_last) into the MAC datapath.
// Revision    : 1.0 - initial parametrised release (successor of the fixed
//               32x8 hidden-unit RAM)
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH  word width in bits
//   ADDR_WIDTH  address width; depth = 2**ADDR_WIDTH
//   INIT_FILE   initial-image name (kept for interface compatibility)
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         asynchronous, active-high reset (RAM contents not cleared)
//   i_wr_en     write strobe, honoured in every state
//   i_wr_addr   write address
//   i_wr_data   write data
//   i_rd_start  start a burst; sampled only while idle
//   i_rd_base   first burst address, sampled with i_rd_start
//   i_rd_len    burst length in words (1..2**ADDR_WIDTH); 0 = no burst
//   i_rd_hold   stall: no read is issued this cycle
//   o_rd_busy   high while the burst engine is in its BURST state
//   o_rd_valid  o_rd_data carries a new word this cycle
//   o_rd_last   o_rd_data is the final word of the burst
//   o_rd_data   registered read data
// Configuration
//   RAM_WR_BYPASS_EN  undefined: read-before-write on a same-address
//                     collision (old word returned).
//                     defined:   write-first forwarding (i_wr_data returned).
// ============================================================================
`default_nettype none

module ram_burst_reader #(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 5,
    parameter string INIT_FILE  = "ram_hidden_contents.txt"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_start,
    input  logic [ADDR_WIDTH-1:0] i_rd_base,
    input  logic [ADDR_WIDTH:0]   i_rd_len,
    input  logic                  i_rd_hold,
    output logic                  o_rd_busy,
    output logic                  o_rd_valid,
    output logic                  o_rd_last,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_BURST = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   c_CNT_ZERO = '0;

    // --------------------------------------------------------------------------
    // Storage
    // --------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];

    // Plain clocked process: the array is never reset, so it stays out of the
    // asynchronously reset datapath below and maps onto block RAM.
    always @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // --------------------------------------------------------------------------
    // Burst engine state
    // --------------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_valid;
    logic                  r_last;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_accept;   // burst request captured this cycle
    logic                  w_issue;    // one word read this cycle
    logic                  w_busy;
    logic                  w_final;    // this issue is the last of the burst
    logic [DATA_WIDTH-1:0] w_rd_word;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                // A zero-length request is dropped rather than starting an empty burst.
                if (i_rd_start && (i_rd_len != c_CNT_ZERO)) begin
                    w_state_nxt = c_BURST;
                end
            end
            c_BURST: begin
                if (!i_rd_hold && (r_cnt == c_CNT_ONE)) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        w_accept = 1'b0;
        w_issue  = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_accept = i_rd_start && (i_rd_len != c_CNT_ZERO);
            end
            c_BURST: begin
                w_busy  = 1'b1;
                w_issue = !i_rd_hold;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign w_final = w_issue && (r_cnt == c_CNT_ONE);

    // Collision handling: on a same-address write in the issue cycle the array
    // read sees the pre-write contents; the bypass variant forwards the new word.
`ifdef RAM_WR_BYPASS_EN
    assign w_rd_word = (i_wr_en && (i_wr_addr == r_ptr)) ? i_wr_data : r_mem[r_ptr];
`else
    assign w_rd_word = r_mem[r_ptr];
`endif

    // Address/count bookkeeping and registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= i_rd_base;
                r_cnt <= i_rd_len;
            end else if (w_issue) begin
                // Pointer wraps naturally at 2**ADDR_WIDTH.
                r_ptr <= r_ptr + c_PTR_ONE;
                r_cnt <= r_cnt - c_CNT_ONE;
            end
            r_valid <= w_issue;
            r_last  <= w_final;
            // Data holds its last value through stalls and idle cycles.
            if (w_issue) begin
                r_data <= w_rd_word;
            end
        end
    end

    assign o_rd_busy  = w_busy;
    assign o_rd_valid = r_valid;
    assign o_rd_last  = r_last;
    assign o_rd_data  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
// ============================================================================
// Module      : tb_ram_burst_reader
// Description : Self-checking bench for ram_burst_reader. Expected words are
//               computed from a bench-side copy of the RAM contents and pushed
//               to a queue when a burst is requested; a negedge monitor pops
//               and compares every valid beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_burst_reader;

  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_wr_en = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_rd_start = 1'b0;
  logic [AW-1:0] i_rd_base = '0;
  logic [AW:0]   i_rd_len = '0;
  logic          i_rd_hold = 1'b0;
  logic          o_rd_busy;
  logic          o_rd_valid;
  logic          o_rd_last;
  logic [DW-1:0] o_rd_data;

  always #5 clk = ~clk;

  ram_burst_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .INIT_FILE  ("")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (i_wr_en),
    .i_wr_addr  (i_wr_addr),
    .i_wr_data  (i_wr_data),
    .i_rd_start (i_rd_start),
    .i_rd_base  (i_rd_base),
    .i_rd_len   (i_rd_len),
    .i_rd_hold  (i_rd_hold),
    .o_rd_busy  (o_rd_busy),
    .o_rd_valid (o_rd_valid),
    .o_rd_last  (o_rd_last),
    .o_rd_data  (o_rd_data)
  );

  // Reference contents and expected-beat queue ({last, data})
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW:0]   exp_q [$];
  logic [DW:0]   mon_e;
  int            n_cmp = 0;
  int            n_err = 0;
  bit            hold_rand = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (o_rd_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got data %0h last %0b expected no beat at t=%0t",
                   o_rd_data, o_rd_last, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", 32'(o_rd_data), 32'(mon_e[DW-1:0]));
          check("beat_last", 32'(o_rd_last), 32'(mon_e[DW]));
          // Busy overlaps every beat except the final one.
          check("beat_busy", 32'(o_rd_busy), 32'(!mon_e[DW]));
        end
      end else if (o_rd_last) begin
        check("last_without_valid", 32'(o_rd_last), 32'd0);
      end
    end
  end

  // Expected stream of a burst: consecutive addresses modulo depth
  task automatic push_burst(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, model_mem[(base + i) % DEPTH]});
    end
  endtask

  // All driving tasks start and end at posedge+1
  task automatic write_word(input int addr, input logic [DW-1:0] data);
    i_wr_en   = 1'b1;
    i_wr_addr = AW'(addr);
    i_wr_data = data;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic start_burst(input int base, input int len);
    i_rd_start = 1'b1;
    i_rd_base  = AW'(base);
    i_rd_len   = (AW+1)'(len);
    @(posedge clk); #1;
    i_rd_start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      if (hold_rand) i_rd_hold = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      cyc++;
    end
    i_rd_hold = 1'b0;
    if (exp_q.size() != 0) begin
      check({name, "_timeout_pending"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
    check({name, "_busy_after"}, 32'(o_rd_busy), 32'd0);
  endtask

  // Cycle-accurate view: cycle c runs from edge c after the start edge
  task automatic check_pattern(input string name, input logic [15:0] vmask,
                               input logic [15:0] bmask, input logic [15:0] hmask,
                               input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      i_rd_hold = hmask[c];
      @(negedge clk);
      check({name, "_valid"}, 32'(o_rd_valid), 32'(vmask[c]));
      check({name, "_busy"}, 32'(o_rd_busy), 32'(bmask[c]));
      @(posedge clk); #1;
    end
    i_rd_hold = 1'b0;
  endtask

  task automatic idle_check(input string name, input int n);
    repeat (n) begin
      @(negedge clk);
      check({name, "_valid"}, 32'(o_rd_valid), 32'd0);
      check({name, "_busy"}, 32'(o_rd_busy), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    // Asynchronous reset before any clock edge
    #2 rst = 1'b1;
    #2;
    check("reset_valid", 32'(o_rd_valid), 32'd0);
    check("reset_last",  32'(o_rd_last),  32'd0);
    check("reset_busy",  32'(o_rd_busy),  32'd0);
    check("reset_data",  32'(o_rd_data),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_check("idle_no_start", 4);

    // Fill every word so the reference contents are fully known
    for (int a = 0; a < DEPTH; a++) write_word(a, DW'($urandom));

    // Basic burst with exact timing
    write_word(4, 8'h11);
    write_word(5, 8'h22);
    write_word(6, 8'h33);
    write_word(7, 8'h44);
    push_burst(4, 4);
    start_burst(4, 4);
    check_pattern("basic", 16'h001E, 16'h000F, 16'h0000, 6);
    drain("basic", 50);

    // Wrap around the top of the address space
    write_word(30, 8'hAA);
    write_word(31, 8'hBB);
    write_word(0, 8'hCC);
    push_burst(30, 3);
    start_burst(30, 3);
    check_pattern("wrap3", 16'h000E, 16'h0007, 16'h0000, 5);
    drain("wrap3", 50);

    // Full-depth burst from base 5
    push_burst(5, DEPTH);
    start_burst(5, DEPTH);
    drain("full_depth", 100);

    // Two-cycle stall after the first issue
    push_burst(0, 3);
    start_burst(0, 3);
    check_pattern("hold", 16'h0032, 16'h001F, 16'h0006, 7);
    drain("hold", 50);

    // Same-address write on the issue edge
    write_word(9, 8'h0F);
    i_rd_start = 1'b1;
    i_rd_base  = AW'(9);
    i_rd_len   = (AW+1)'(1);
    @(posedge clk); #1;
    i_rd_start = 1'b0;
    i_wr_en    = 1'b1;
    i_wr_addr  = AW'(9);
    i_wr_data  = 8'hF0;
`ifdef RAM_WR_BYPASS_EN
    exp_q.push_back({1'b1, 8'hF0});
`else
    exp_q.push_back({1'b1, 8'h0F});
`endif
    @(posedge clk); #1;
    i_wr_en = 1'b0;
    model_mem[9] = 8'hF0;
    drain("collision", 50);
    push_burst(9, 1);
    start_burst(9, 1);
    drain("collision_after", 50);

    // Zero-length request is ignored
    start_burst(12, 0);
    idle_check("len_zero", 4);

    // Start request during a burst is ignored
    push_burst(10, 6);
    start_burst(10, 6);
    @(posedge clk); #1;
    i_rd_start = 1'b1;
    i_rd_base  = AW'(20);
    i_rd_len   = (AW+1)'(3);
    @(posedge clk); #1;
    i_rd_start = 1'b0;
    drain("start_in_burst", 50);
    idle_check("start_in_burst_idle", 3);

    // Restart sampled in the rd_last cycle
    push_burst(3, 2);
    start_burst(3, 2);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (o_rd_valid && o_rd_last) found = 1'b1;
    end
    check("restart_last_seen", 32'(found), 32'd1);
    push_burst(7, 2);
    i_rd_start = 1'b1;
    i_rd_base  = AW'(7);
    i_rd_len   = (AW+1)'(2);
    @(posedge clk); #1;
    i_rd_start = 1'b0;
    check_pattern("restart", 16'h0006, 16'h0003, 16'h0000, 4);
    drain("restart", 50);

    // Reset in the middle of a burst
    push_burst(0, 20);
    start_burst(0, 20);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(o_rd_valid), 32'd0);
    check("midrst_last",  32'(o_rd_last),  32'd0);
    check("midrst_busy",  32'(o_rd_busy),  32'd0);
    check("midrst_data",  32'(o_rd_data),  32'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle_check("post_reset", 4);
    push_burst(16, 4);
    start_burst(16, 4);
    drain("post_reset_burst", 50);

    // Randomised writes and bursts with random stalls
    for (int it = 0; it < 15; it++) begin
      int nw;
      int base;
      int len;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) write_word($urandom_range(0, DEPTH - 1), DW'($urandom));
      base = $urandom_range(0, DEPTH - 1);
      len  = $urandom_range(1, DEPTH);
      hold_rand = 1'b1;
      push_burst(base, len);
      start_burst(base, len);
      drain("random", 400);
      hold_rand = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
